// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide engine with divide shortcuts, flush abort and pipeline stall
module ex_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam int SW    = XLEN + BITS_PER_CYCLE;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   opx_q, opx_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;

    logic              accept, is_div, signed_a, sgn_a, sgn_b, div_zero, div_ovf, shortcut, last;
    logic [XLEN-1:0]   abs_a, abs_b, quo_fix, rem_fix, fix_sel;
    logic [SW-1:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc, div_acc, prod_fix;
    logic [XLEN:0]     trial;

    // Operand conditioning: magnitudes plus sign flags, so CALC is purely unsigned
    assign accept   = state_q == IDLE && start && !flush;
    assign is_div   = funct3[2];
    assign signed_a = ~(funct3[0] & (funct3[1] | funct3[2]));
    assign sgn_a    = signed_a & op_a[XLEN-1];
    assign sgn_b    = signed_a & (funct3 != 3'b010) & op_b[XLEN-1];
    assign abs_a    = sgn_a ? -op_a : op_a;
    assign abs_b    = sgn_b ? -op_b : op_b;
    assign div_zero = is_div && op_b == '0;
    assign div_ovf  = is_div && !funct3[0] && op_a == MIN_INT && op_b == '1;
    assign shortcut = div_zero | div_ovf;
    assign last     = cnt_q == CW'(STEPS - 1);

    // Multiply: acc = {partial, multiplier}; add multiplicand*digit to top, shift right one digit
    assign mul_sum = SW'(acc_q[2*XLEN-1:XLEN]) + SW'(opx_q) * SW'(acc_q[BITS_PER_CYCLE-1:0]);
    assign mul_acc = {mul_sum, acc_q[XLEN-1:BITS_PER_CYCLE]};

    // Divide: acc = {remainder, quotient}; restoring step per bit, quotient bits shift in at the bottom
    always_comb begin
        div_acc = acc_q;
        trial   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial   = {div_acc[2*XLEN-1:XLEN], div_acc[XLEN-1]} - {1'b0, opx_q};
            div_acc = trial[XLEN] ? {div_acc[2*XLEN-2:0], 1'b0} : {trial[XLEN-1:0], div_acc[XLEN-2:0], 1'b1};
        end
    end

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign fix_sel  = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix)
                              : (f3_q[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = flush               ? IDLE :
                  state_q == IDLE     ? (start ? (shortcut ? DONE : CALC) : IDLE) :
                  state_q == CALC     ? (last ? FIX : CALC) :
                  state_q == FIX      ? DONE : IDLE;
    end

    always_comb begin
        stall  = accept || state_q == CALC || state_q == FIX;
        done   = state_q == DONE && !flush;
        result = result_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        opx_d    = opx_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        if (accept) begin
            f3_d   = funct3;
            opx_d  = is_div ? abs_b : abs_a;
            acc_d  = {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
            neg_d  = sgn_a ^ sgn_b;
            rneg_d = sgn_a;
            cnt_d  = '0;
            if (shortcut) result_d = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN_INT);
        end else if (state_q == CALC) begin
            acc_d = f3_q[2] ? div_acc : mul_acc;
            cnt_d = cnt_q + 1'b1;
        end else if (state_q == FIX && !flush) begin
            result_d = fix_sel;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            opx_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            opx_q    <= opx_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed checks of ex_muldiv_unit at one and four bits per cycle
module tb_ex_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall1, done1, stall4, done4;
    logic [31:0] result1, result4;

    int          pass_cnt = 0;
    int          total = 0;
    int          d1cyc, d4cyc, d1n, d4n;
    logic [31:0] r1, r4;
    logic        stall_hist [0:63];

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .stall(stall1), .done(done1), .result(result1)
    );

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clock(clock), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .stall(stall4), .done(done4), .result(result4)
    );

    always #5 clock = ~clock;

    // Pulses start for cycle 0 and records done timing/results of both units over 40 cycles
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        d1cyc = -1; d4cyc = -1; d1n = 0; d4n = 0; r1 = 'x; r4 = 'x;
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            stall_hist[c] = stall1;
            if (done1) begin
                d1n++;
                if (d1cyc < 0) begin d1cyc = c; r1 = result1; end
            end
            if (done4) begin
                d4n++;
                if (d4cyc < 0) begin d4cyc = c; r4 = result4; end
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        total++; if (result1 !== 32'h0) $display("FAIL reset_result1: got %h expected %h", result1, 32'h0); else pass_cnt++;
        total++; if (done1 !== 1'b0) $display("FAIL reset_done1: got %b expected 0", done1); else pass_cnt++;
        total++; if (stall1 !== 1'b0) $display("FAIL reset_stall1: got %b expected 0", stall1); else pass_cnt++;
        total++; if (result4 !== 32'h0) $display("FAIL reset_result4: got %h expected %h", result4, 32'h0); else pass_cnt++;
    endtask

    task automatic test_mul;
        int highs;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD);
        highs = 0;
        for (int c = 0; c < 34; c++) if (stall_hist[c] === 1'b1) highs++;
        total++; if (r1 !== 32'hFFFFFFEB) $display("FAIL mul_result1: got %h expected %h", r1, 32'hFFFFFFEB); else pass_cnt++;
        total++; if (d1cyc !== 34) $display("FAIL mul_done_cycle1: got %0d expected 34", d1cyc); else pass_cnt++;
        total++; if (d1n !== 1) $display("FAIL mul_done_pulses1: got %0d expected 1", d1n); else pass_cnt++;
        total++; if (highs !== 34) $display("FAIL mul_stall_high: got %0d cycles expected 34", highs); else pass_cnt++;
        total++; if (stall_hist[34] !== 1'b0) $display("FAIL mul_stall_done: got %b expected 0", stall_hist[34]); else pass_cnt++;
        total++; if (r4 !== 32'hFFFFFFEB) $display("FAIL mul_result4: got %h expected %h", r4, 32'hFFFFFFEB); else pass_cnt++;
        total++; if (d4cyc !== 10) $display("FAIL mul_done_cycle4: got %0d expected 10", d4cyc); else pass_cnt++;
        total++; if (d4n !== 1) $display("FAIL mul_done_pulses4: got %0d expected 1", d4n); else pass_cnt++;
    endtask

    task automatic test_mulh;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total++; if (r1 !== 32'hFFFFFFFE) $display("FAIL mulhu_result1: got %h expected %h", r1, 32'hFFFFFFFE); else pass_cnt++;
        total++; if (r4 !== 32'hFFFFFFFE) $display("FAIL mulhu_result4: got %h expected %h", r4, 32'hFFFFFFFE); else pass_cnt++;
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total++; if (r1 !== 32'h0) $display("FAIL mulh_result1: got %h expected %h", r1, 32'h0); else pass_cnt++;
        total++; if (r4 !== 32'h0) $display("FAIL mulh_result4: got %h expected %h", r4, 32'h0); else pass_cnt++;
        run_op(3'b010, 32'hFFFFFFFF, 32'h00000002);
        total++; if (r1 !== 32'hFFFFFFFF) $display("FAIL mulhsu_result1: got %h expected %h", r1, 32'hFFFFFFFF); else pass_cnt++;
        total++; if (r4 !== 32'hFFFFFFFF) $display("FAIL mulhsu_result4: got %h expected %h", r4, 32'hFFFFFFFF); else pass_cnt++;
        total++; if (d4cyc !== 10) $display("FAIL mulhsu_done_cycle4: got %0d expected 10", d4cyc); else pass_cnt++;
    endtask

    task automatic test_shortcut;
        run_op(3'b101, 32'd5, 32'd0);
        total++; if (r1 !== 32'hFFFFFFFF) $display("FAIL divu_zero_result1: got %h expected %h", r1, 32'hFFFFFFFF); else pass_cnt++;
        total++; if (d1cyc !== 1) $display("FAIL divu_zero_cycle1: got %0d expected 1", d1cyc); else pass_cnt++;
        total++; if (d4cyc !== 1) $display("FAIL divu_zero_cycle4: got %0d expected 1", d4cyc); else pass_cnt++;
        total++; if (stall_hist[0] !== 1'b1) $display("FAIL divu_zero_stall0: got %b expected 1", stall_hist[0]); else pass_cnt++;
        total++; if (stall_hist[1] !== 1'b0) $display("FAIL divu_zero_stall1: got %b expected 0", stall_hist[1]); else pass_cnt++;
        run_op(3'b110, 32'd5, 32'd0);
        total++; if (r1 !== 32'd5) $display("FAIL rem_zero_result1: got %h expected %h", r1, 32'd5); else pass_cnt++;
        total++; if (d1cyc !== 1) $display("FAIL rem_zero_cycle1: got %0d expected 1", d1cyc); else pass_cnt++;
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF);
        total++; if (r1 !== 32'h80000000) $display("FAIL div_ovf_result1: got %h expected %h", r1, 32'h80000000); else pass_cnt++;
        total++; if (d1cyc !== 1) $display("FAIL div_ovf_cycle1: got %0d expected 1", d1cyc); else pass_cnt++;
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF);
        total++; if (r1 !== 32'h0) $display("FAIL rem_ovf_result1: got %h expected %h", r1, 32'h0); else pass_cnt++;
        total++; if (r4 !== 32'h0) $display("FAIL rem_ovf_result4: got %h expected %h", r4, 32'h0); else pass_cnt++;
    endtask

    task automatic test_div;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2);
        total++; if (r1 !== 32'hFFFFFFFD) $display("FAIL div_result1: got %h expected %h", r1, 32'hFFFFFFFD); else pass_cnt++;
        total++; if (r4 !== 32'hFFFFFFFD) $display("FAIL div_result4: got %h expected %h", r4, 32'hFFFFFFFD); else pass_cnt++;
        total++; if (d1cyc !== 34) $display("FAIL div_done_cycle1: got %0d expected 34", d1cyc); else pass_cnt++;
        run_op(3'b110, 32'hFFFFFFF9, 32'd2);
        total++; if (r1 !== 32'hFFFFFFFF) $display("FAIL rem_result1: got %h expected %h", r1, 32'hFFFFFFFF); else pass_cnt++;
        total++; if (r4 !== 32'hFFFFFFFF) $display("FAIL rem_result4: got %h expected %h", r4, 32'hFFFFFFFF); else pass_cnt++;
        run_op(3'b101, 32'd100, 32'd7);
        total++; if (r1 !== 32'd14) $display("FAIL divu_result1: got %h expected %h", r1, 32'd14); else pass_cnt++;
        total++; if (r4 !== 32'd14) $display("FAIL divu_result4: got %h expected %h", r4, 32'd14); else pass_cnt++;
        total++; if (d4cyc !== 10) $display("FAIL divu_done_cycle4: got %0d expected 10", d4cyc); else pass_cnt++;
        run_op(3'b111, 32'd100, 32'd7);
        total++; if (r1 !== 32'd2) $display("FAIL remu_result1: got %h expected %h", r1, 32'd2); else pass_cnt++;
        total++; if (r4 !== 32'd2) $display("FAIL remu_result4: got %h expected %h", r4, 32'd2); else pass_cnt++;
    endtask

    task automatic test_flush;
        int          dn;
        int          dcyc;
        logic [31:0] rsv;
        dn = 0; dcyc = -1; rsv = 'x;
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
        for (int c = 0; c < 60; c++) begin
            start = (c == 0) || (c == 12) || (c >= 13 && c <= 20 && (c % 2) == 1);
            flush = (c == 10);
            @(negedge clock);
            if (done1) begin
                dn++;
                if (dcyc < 0) dcyc = c;
            end
            if (c == 11) begin
                total++; if (dn !== 0) $display("FAIL flush_no_done: got %0d pulses expected 0", dn); else pass_cnt++;
                total++; if (result1 !== 32'd2) $display("FAIL flush_result_kept: got %h expected %h", result1, 32'd2); else pass_cnt++;
                total++; if (stall1 !== 1'b0) $display("FAIL flush_idle_stall: got %b expected 0", stall1); else pass_cnt++;
            end
            if (c == 46) rsv = result1;
            @(posedge clock); #1;
        end
        start = 1'b0; flush = 1'b0;
        total++; if (dn !== 1) $display("FAIL restart_done_pulses: got %0d expected 1", dn); else pass_cnt++;
        total++; if (dcyc !== 46) $display("FAIL restart_done_cycle: got %0d expected 46", dcyc); else pass_cnt++;
        total++; if (rsv !== 32'd15) $display("FAIL restart_result: got %h expected %h", rsv, 32'd15); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        total++; if (stall1 !== 1'b1) $display("FAIL midreset_busy: got %b expected 1", stall1); else pass_cnt++;
        reset = 1'b0;
        #1;
        total++; if (result1 !== 32'h0) $display("FAIL midreset_result1: got %h expected %h", result1, 32'h0); else pass_cnt++;
        total++; if (done1 !== 1'b0) $display("FAIL midreset_done1: got %b expected 0", done1); else pass_cnt++;
        total++; if (stall1 !== 1'b0) $display("FAIL midreset_stall1: got %b expected 0", stall1); else pass_cnt++;
        total++; if (result4 !== 32'h0) $display("FAIL midreset_result4: got %h expected %h", result4, 32'h0); else pass_cnt++;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        test_reset;
        reset = 1'b1;
        @(posedge clock); #1;
        test_mul;
        test_mulh;
        test_shortcut;
        test_div;
        test_flush;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine in the EX pipe stage, alongside the single-cycle ALU and its ALU-control decode.
- Accepts one M-extension operation per start pulse (funct7 = 0000001), decoded by funct3.
- Computes a radix-2^BITS_PER_CYCLE shift-add product or restoring quotient/remainder over multiple cycles.
- Stalls the pipeline until the result is ready; supports abort on flush.

Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 1, product/quotient bits retired per CALC cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  M-op present in EX; sampled only in IDLE.
- flush  input  1  pipeline flush; aborts any operation in progress.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value (multiplicand/dividend).
- op_b  input  XLEN  rs2 value (multiplier/divisor).
- stall  output  1  hold IF/ID/EX; combinational.
- done  output  1  one-cycle pulse; result valid in this cycle.
- result  output  XLEN  registered result; held until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; result=0; done=0; counter=0; internal operand registers=0.
- States are IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 accepts the operation in cycle 0: latch funct3, compute absolute values for signed forms, record result-sign flags.
  - MUL/MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - DIV/REM: both operands signed.
  - Unsigned forms take operands as-is.
  - Shortcut cases go to DONE; all other accepted operations go to CALC with counter=0.
- Shortcut cases (done at cycle 1):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV gives -2^(XLEN-1); REM gives 0.
- CALC:
  - Runs XLEN/BITS_PER_CYCLE cycles; counter increments each cycle.
  - Leaves for FIX when counter = XLEN/BITS_PER_CYCLE - 1.
  - Multiply uses a 2*XLEN unsigned accumulator.
  - Divide uses an XLEN remainder and XLEN quotient with a restoring subtract per bit.
- FIX (one cycle):
  - Negate the 2*XLEN product if the sign flag is set; negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Select the low half (MUL), high half (MULH/MULHSU/MULHU), quotient or remainder.
  - Register the selection into result, then go to DONE.
- DONE: done=1 for exactly one cycle; start is ignored; next state is IDLE.
- Normal latency: start accepted at cycle 0; done at cycle XLEN/BITS_PER_CYCLE + 2 (34 for defaults).
- stall = (start & state==IDLE & ~flush) | state==CALC | state==FIX.
  - stall is 0 in DONE, so the instruction advances in the done cycle.
  - stall is 0 in IDLE when start=0.
- start while in CALC/FIX/DONE is ignored; no queueing.
- flush in any state: next state IDLE, done not asserted, result unchanged. flush has priority over start in the same cycle.
- reset asserted mid-operation: immediate IDLE, outputs as at reset.
- Unsigned/signed arithmetic uses explicit widths; no implicit sign extension beyond what is stated.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly at cycle 34; stall high cycles 0-33, low at cycle 34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done at cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Start MUL, assert flush at cycle 10 -> IDLE, no done pulse, result unchanged; a new start at cycle 12 completes normally. Toggling start during CALC -> no effect.
- reset low at cycle 5 of a DIV -> result=0, done=0, stall=0 immediately. Repeat the first three scenarios with BITS_PER_CYCLE=4 -> done at cycle 10.
